// File: rtl/mmio_serial_tx.sv
// Memory-mapped serial transmitter: store words to TX_ADDR are queued in a
// 4-deep FIFO and shifted out LSB first inside a start/stop frame.
module mmio_serial_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [15:0] TX_ADDR      = 16'hFFF0,
    parameter logic [15:0] STAT_ADDR    = 16'hFFF1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [15:0] ReadData,
    output logic        TxOut,
    output logic        Busy,
    output logic        Full
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [15:0] fifo_q [4];
    logic [15:0] fifo_d [4];

    logic        fifo_full;
    logic        wr_hit;
    logic        push;
    logic        pop;
    logic        baud_done;
    logic [15:0] status;

    assign fifo_full = (count_q == 3'd4);
    assign wr_hit    = MemWrite && (Address == TX_ADDR);
    assign push      = wr_hit && !fifo_full;
    assign baud_done = (baud_q == BAUD_LAST);

    // Transmit FSM; TxOut is the registered level of the current state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = 16'd0;
                    bit_d   = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[15:1]};
                    if (bit_q == 4'd15) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d  = 16'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                baud_d  = 16'd0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; the full check uses the pre-edge count, so a pop at
    // the same edge never makes room for a push.
    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = WriteData;
        end
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wr_hit && fifo_full) begin
            ovf_d = 1'b1;
        end else if (MemRead && (Address == STAT_ADDR)) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 4'd0;
            tx_q     <= 1'b1;
            count_q  <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Data storage needs no reset; it is only read behind valid control state.
    always_ff @(posedge CLK) begin
        fifo_q  <= fifo_d;
        shift_q <= shift_d;
    end

    assign Busy     = (state_q != IDLE) || (count_q != 3'd0);
    assign Full     = fifo_full;
    assign status   = {10'b0, count_q, ovf_q, fifo_full, Busy};
    assign ReadData = (Address == STAT_ADDR) ? status : 16'h0000;
    assign TxOut    = tx_q;

endmodule

// File: tb/tb_mmio_serial_tx.sv
// Bench for mmio_serial_tx: a frame-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mmio_serial_tx;

    localparam int          CPB   = 4;
    localparam int          FRAME = 18 * CPB;
    localparam logic [15:0] TXA   = 16'hFFF0;
    localparam logic [15:0] STA   = 16'hFFF1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] Address = 16'h0;
    logic [15:0] WriteData = 16'h0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [15:0] ReadData;
    logic        TxOut;
    logic        Busy;
    logic        Full;

    int pass_cnt = 0;
    int total_cnt = 0;

    mmio_serial_tx dut (
        .CLK(CLK), .RST_N(RST_N), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .TxOut(TxOut), .Busy(Busy), .Full(Full)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: queue of pending words plus a frame-time counter for the word on the line.
    logic [15:0] mq[$];
    logic        m_in_frame = 1'b0;
    int          m_t = 0;
    logic [15:0] m_cur = 16'h0;
    logic        m_ovf = 1'b0;
    logic        m_tx = 1'b1;

    function automatic logic frame_level(input int tt, input logic [15:0] w);
        if (tt < CPB) return 1'b0;
        else if (tt < 17 * CPB) return w[(tt - CPB) / CPB];
        else return 1'b1;
    endfunction

    initial begin
        logic push_ok, ovf_set, rd_clr;
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                mq.delete();
                m_in_frame = 1'b0;
                m_t = 0;
                m_ovf = 1'b0;
                m_tx = 1'b1;
            end else begin
                push_ok = MemWrite && (Address == TXA) && (mq.size() < 4);
                ovf_set = MemWrite && (Address == TXA) && (mq.size() == 4);
                rd_clr  = MemRead && (Address == STA);
                m_tx = m_in_frame ? frame_level(m_t, m_cur) : 1'b1;
                if (m_in_frame) begin
                    m_t++;
                    if (m_t == FRAME) m_in_frame = 1'b0;
                end else if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_in_frame = 1'b1;
                    m_t = 0;
                end
                if (push_ok) mq.push_back(WriteData);
                if (ovf_set) m_ovf = 1'b1;
                else if (rd_clr) m_ovf = 1'b0;
            end
        end
    end

    function automatic logic [15:0] model_rdata();
        logic       b;
        logic [2:0] n;
        b = m_in_frame || (mq.size() != 0);
        n = 3'(mq.size());
        if (Address != STA) return 16'h0000;
        return {10'b0, n, m_ovf, (mq.size() == 4), b};
    endfunction

    always @(negedge CLK) begin
        chk("model_tx", TxOut, m_tx);
        chk("model_busy", Busy, m_in_frame || (mq.size() != 0));
        chk("model_full", Full, mq.size() == 4);
        chk("model_rdata", ReadData, model_rdata());
    end

    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we, input logic re);
        Address = a; WriteData = d; MemWrite = we; MemRead = re;
        @(posedge CLK); #1;
        Address = 16'h0; WriteData = 16'h0; MemWrite = 1'b0; MemRead = 1'b0;
    endtask

    task automatic peek_status(input string name, input logic [15:0] exp);
        Address = STA; #1;
        chk(name, ReadData, exp);
        Address = 16'h0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (Busy && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        chk(name, Busy, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [17:0] frame_bits;
        int lows, busys;

        // Reset state
        Address = STA;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx", TxOut, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_full", Full, 1'b0);
        chk("rst_status", ReadData, 16'h0000);
        Address = 16'h0;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Single word 0xA5C3: latency then start, 16 data bits, stop
        frame_bits = {1'b1, 16'hA5C3, 1'b0};
        cyc(TXA, 16'hA5C3, 1'b1, 1'b0);
        chk("lat_k", TxOut, 1'b1);
        @(posedge CLK); #1;
        chk("lat_k1", TxOut, 1'b1);
        @(posedge CLK); #1;
        chk("lat_k2", TxOut, 1'b0);
        for (int j = 0; j < 18; j++) begin
            repeat ((j == 0) ? 1 : 4) @(posedge CLK);
            #1;
            chk($sformatf("a5c3_bit%0d", j), TxOut, frame_bits[j]);
        end
        wait_idle("single_idle", 200);

        // Fill and overflow, then drain
        for (int i = 1; i <= 6; i++) cyc(TXA, 16'(i), 1'b1, 1'b0);
        peek_status("fill_status", 16'h0027);
        cyc(STA, 16'h0, 1'b0, 1'b1);
        peek_status("after_read_status", 16'h0023);
        wait_idle("drain_idle", 2000);
        peek_status("drain_status", 16'h0000);

        // Address filter
        cyc(16'hFFF2, 16'h1234, 1'b1, 1'b1);
        Address = 16'hFFF2; #1;
        chk("filter_rdata", ReadData, 16'h0000);
        Address = 16'h0;
        lows = 0; busys = 0;
        repeat (100) begin
            @(posedge CLK); #1;
            if (!TxOut) lows++;
            if (Busy) busys++;
        end
        chk("filter_no_frame", lows, 0);
        chk("filter_no_busy", busys, 0);

        // Overflow set while a read strobe is also active
        for (int i = 0; i < 5; i++) cyc(TXA, 16'h0011 + 16'(i), 1'b1, 1'b0);
        peek_status("full_no_ovf", 16'h0023);
        cyc(TXA, 16'h0099, 1'b1, 1'b1);
        peek_status("ovf_with_read", 16'h0027);
        cyc(STA, 16'h0, 1'b0, 1'b1);
        peek_status("ovf_cleared", 16'h0023);
        wait_idle("ovf_drain_idle", 2000);

        // Reset during DATA bit 7 with two words buffered
        cyc(TXA, 16'h1111, 1'b1, 1'b0);
        cyc(TXA, 16'h2222, 1'b1, 1'b0);
        cyc(TXA, 16'h3333, 1'b1, 1'b0);
        peek_status("pre_reset_status", 16'h0011);
        repeat (32) @(posedge CLK);
        #2;
        chk("mid_frame_busy", Busy, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("async_rst_tx", TxOut, 1'b1);
        chk("async_rst_busy", Busy, 1'b0);
        chk("async_rst_full", Full, 1'b0);
        peek_status("async_rst_status", 16'h0000);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        lows = 0; busys = 0;
        repeat (200) begin
            @(posedge CLK); #1;
            if (!TxOut) lows++;
            if (Busy) busys++;
        end
        chk("post_rst_no_frame", lows, 0);
        chk("post_rst_no_busy", busys, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
